// File: rtl/uio_bus_arbiter.sv
// Round-robin owner of the shared uio pad bank with turnaround and hold limit.
// Define UIO_ARB_PREEMPT_EN to make requester 0 preempt any other owner.
module uio_bus_arbiter #(
    parameter int NREQ     = 4,
    parameter int MAX_HOLD = 16,
    parameter int TURN_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   dir,
    input  logic [8*NREQ-1:0] wdata,
    output logic [NREQ-1:0]   gnt,
    output logic [7:0]        rdata,
    output logic              rvalid,
    output logic              busy,
    input  logic [7:0]        uio_in,
    output logic [7:0]        uio_out,
    output logic [7:0]        uio_oe
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [7:0] HOLD_W = 8'(MAX_HOLD);
    localparam logic [2:0] TURN_W = 3'(TURN_CYC);
    localparam logic [IW-1:0] LAST_IDX = IW'(NREQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        TURN,
        OWN
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   w_q, w_d;
    logic            dir_q, dir_d;
    logic [IW-1:0]   last_q, last_d;
    logic            last_dir_q, last_dir_d;
    logic [7:0]      hold_q, hold_d;
    logic [2:0]      turn_q, turn_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [7:0]      rdata_q, rdata_d;
    logic            rvalid_q, rvalid_d;
    logic            busy_q, busy_d;
    logic [7:0]      uio_out_q, uio_out_d;
    logic [7:0]      uio_oe_q, uio_oe_d;
`ifdef UIO_ARB_PREEMPT_EN
    logic            preempt_q, preempt_d;
    logic            pre_hit;
`endif

    logic [IW-1:0]   rr_win;
    logic [IW-1:0]   rr_cand;
    logic            rr_found;
    logic [IW-1:0]   pick;
    logic            enter_own;
    logic [IW-1:0]   ew;
    logic            edir;
    logic            release_own;

    // Search starts one past the previous winner and wraps at NREQ.
    always_comb begin
        rr_win   = '0;
        rr_found = 1'b0;
        rr_cand  = last_q;
        for (int k = 0; k < NREQ; k++) begin
            rr_cand = (rr_cand == LAST_IDX) ? '0 : rr_cand + 1'b1;
            if (!rr_found && req[rr_cand]) begin
                rr_found = 1'b1;
                rr_win   = rr_cand;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        w_d         = w_q;
        dir_d       = dir_q;
        last_d      = last_q;
        last_dir_d  = last_dir_q;
        hold_d      = hold_q;
        turn_d      = turn_q;
        gnt_d       = gnt_q;
        uio_out_d   = uio_out_q;
        uio_oe_d    = uio_oe_q;
        enter_own   = 1'b0;
        ew          = w_q;
        edir        = dir_q;
        pick        = rr_win;
        release_own = 1'b0;
`ifdef UIO_ARB_PREEMPT_EN
        preempt_d   = preempt_q;
        pre_hit     = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                gnt_d     = '0;
                uio_out_d = 8'h00;
                uio_oe_d  = 8'h00;
                if (ena && (|req)) begin
`ifdef UIO_ARB_PREEMPT_EN
                    if (preempt_q && req[0]) pick = '0;
                    preempt_d = 1'b0;
`endif
                    w_d   = pick;
                    dir_d = dir[pick];
                    if (dir[pick] == last_dir_q) begin
                        enter_own = 1'b1;
                        ew        = pick;
                        edir      = dir[pick];
                    end else begin
                        state_d = TURN;
                        turn_d  = 3'd1;
                    end
                end
            end
            TURN: begin
                if (turn_q >= TURN_W) enter_own = 1'b1;
                else turn_d = turn_q + 3'd1;
            end
            OWN: begin
                release_own = !req[w_q] || (hold_q >= HOLD_W) || !ena;
`ifdef UIO_ARB_PREEMPT_EN
                pre_hit = (w_q != '0) && req[0];
                if (pre_hit) begin
                    release_own = 1'b1;
                    preempt_d   = 1'b1;
                end
`endif
                if (release_own) begin
                    state_d   = IDLE;
                    gnt_d     = '0;
                    uio_out_d = 8'h00;
                    uio_oe_d  = 8'h00;
                    hold_d    = 8'd0;
                end else begin
                    hold_d    = hold_q + 8'd1;
                    uio_out_d = dir_q ? wdata[8*int'(w_q) +: 8] : 8'h00;
                end
            end
            default: begin
                state_d   = IDLE;
                gnt_d     = '0;
                uio_out_d = 8'h00;
                uio_oe_d  = 8'h00;
            end
        endcase

        if (enter_own) begin
            state_d    = OWN;
            w_d        = ew;
            dir_d      = edir;
            last_d     = ew;
            last_dir_d = edir;
            hold_d     = 8'd1;
            gnt_d      = '0;
            gnt_d[ew]  = 1'b1;
            uio_oe_d   = edir ? 8'hFF : 8'h00;
            uio_out_d  = edir ? wdata[8*int'(ew) +: 8] : 8'h00;
        end
    end

    // Read data trails the grant by one cycle; rdata keeps its last sample.
    always_comb begin
        rvalid_d = (state_q == OWN) && !dir_q;
        rdata_d  = rvalid_d ? uio_in : rdata_q;
        busy_d   = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            w_q        <= '0;
            dir_q      <= 1'b0;
            last_q     <= LAST_IDX;
            last_dir_q <= 1'b0;
            hold_q     <= 8'd0;
            turn_q     <= 3'd0;
            gnt_q      <= '0;
            rdata_q    <= 8'h00;
            rvalid_q   <= 1'b0;
            busy_q     <= 1'b0;
            uio_out_q  <= 8'h00;
            uio_oe_q   <= 8'h00;
`ifdef UIO_ARB_PREEMPT_EN
            preempt_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            w_q        <= w_d;
            dir_q      <= dir_d;
            last_q     <= last_d;
            last_dir_q <= last_dir_d;
            hold_q     <= hold_d;
            turn_q     <= turn_d;
            gnt_q      <= gnt_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
            busy_q     <= busy_d;
            uio_out_q  <= uio_out_d;
            uio_oe_q   <= uio_oe_d;
`ifdef UIO_ARB_PREEMPT_EN
            preempt_q  <= preempt_d;
`endif
        end
    end

    assign gnt     = gnt_q;
    assign rdata   = rdata_q;
    assign rvalid  = rvalid_q;
    assign busy    = busy_q;
    assign uio_out = uio_out_q;
    assign uio_oe  = uio_oe_q;

endmodule
